rom_msg_sequencer: RTL and testbench

//  Sequences input_ROM reads for the Morse encoder path. On a start command it walks the ROM from a

---
 rtl/rom_msg_sequencer_pkg.sv | 24 ++
 rtl/rom_msg_sequencer_if.sv | 22 ++
 rtl/rom_msg_sequencer_adr_counter.sv | 30 +++
 rtl/rom_msg_sequencer.sv | 140 ++++++++++++++
 tb/tb_rom_msg_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/rom_msg_sequencer_pkg.sv
// Shared constants, FSM state type and helpers for the ROM message sequencer.
package rom_msg_sequencer_pkg;

  localparam int ADR_W = 17;
  localparam int DATA_W = 8;
  localparam int ROM_LAT = 1;
  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [DATA_W-1:0] TERM_CHAR = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  // Character count increment that sticks at all-ones instead of wrapping.
  function automatic logic [ADR_W-1:0] sat_inc(input logic [ADR_W-1:0] v);
    return (v == {ADR_W{1'b1}}) ? v : v + {{(ADR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rom_msg_sequencer_if.sv
// ROM read port plus the character valid/ready stream towards the code generator.
interface rom_msg_sequencer_if;
  import rom_msg_sequencer_pkg::*;

  logic              rom_cs;
  logic [ADR_W-1:0]  rom_adr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] chr;
  logic              chr_valid;
  logic              chr_ready;

  modport master (
    output rom_cs, rom_adr, chr, chr_valid,
    input  rom_data, chr_ready
  );

  modport slave (
    input  rom_cs, rom_adr, chr, chr_valid,
    output rom_data, chr_ready
  );

endinterface

// File: rtl/rom_msg_sequencer_adr_counter.sv
// ROM address register: loads the message base, steps by one with silent wrap.
module rom_msg_sequencer_adr_counter
  import rom_msg_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [ADR_W-1:0] i_base,
  output logic [ADR_W-1:0] o_adr
);

  logic [ADR_W-1:0] r_adr;

  // Address register: load has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr <= {ADR_W{1'b0}};
    end else if (i_load) begin
      r_adr <= i_base;
    end else if (i_inc) begin
      r_adr <= r_adr + {{(ADR_W-1){1'b0}}, 1'b1};
    end else begin
      r_adr <= r_adr;
    end
  end

  assign o_adr = r_adr;

endmodule

// File: rtl/rom_msg_sequencer.sv
// Walks the input ROM from a base address and hands characters downstream until a
// terminator byte or the length limit ends the message.
module rom_msg_sequencer
  import rom_msg_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADR_W-1:0]  i_base_adr,
  input  logic [ADR_W-1:0]  i_max_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_trunc,
  output logic [ADR_W-1:0]  o_chr_cnt,
  rom_msg_sequencer_if.master bus
);

  seq_state_t        r_state;
  logic              r_rom_cs;
  logic [DATA_W-1:0] r_chr;
  logic              r_chr_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_trunc;
  logic [ADR_W-1:0]  r_chr_cnt;
  logic [LAT_W-1:0]  r_lat_cnt;

  logic              w_hs;
  logic              w_len_hit;
  logic              w_adr_load;
  logic              w_adr_inc;
  logic [ADR_W-1:0]  w_cnt_nxt;
  logic [ADR_W-1:0]  w_adr;

  // Handshake and stop decisions; the address only advances when another fetch follows.
  always_comb begin
    w_hs       = r_chr_valid & bus.chr_ready;
    w_cnt_nxt  = sat_inc(r_chr_cnt);
    w_len_hit  = (i_max_len != {ADR_W{1'b0}}) && (w_cnt_nxt == i_max_len);
    w_adr_load = (r_state == ST_IDLE) && i_start;
    w_adr_inc  = (r_state == ST_PRESENT) && w_hs && !w_len_hit;
  end

  rom_msg_sequencer_adr_counter u_adr_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_adr_load),
    .i_inc  (w_adr_inc),
    .i_base (i_base_adr),
    .o_adr  (w_adr)
  );

  // Sequencer FSM; every output is set from the transition so it lands registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rom_cs    <= 1'b0;
      r_chr       <= {DATA_W{1'b0}};
      r_chr_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_trunc     <= 1'b0;
      r_chr_cnt   <= {ADR_W{1'b0}};
      r_lat_cnt   <= {LAT_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_FETCH;
            r_busy    <= 1'b1;
            r_trunc   <= 1'b0;
            r_chr_cnt <= {ADR_W{1'b0}};
            r_rom_cs  <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_rom_cs <= 1'b0;
          if (ROM_LAT > 1) begin
            r_lat_cnt <= LAT_W'(ROM_LAT - 1);
            r_state   <= ST_WAIT;
          end else begin
            r_state <= ST_CHECK;
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == LAT_W'(1)) begin
            r_state <= ST_CHECK;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        ST_CHECK: begin
          if (bus.rom_data == TERM_CHAR) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_chr       <= bus.rom_data;
            r_chr_valid <= 1'b1;
            r_state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (w_hs) begin
            r_chr_valid <= 1'b0;
            r_chr_cnt   <= w_cnt_nxt;
            if (w_len_hit) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_trunc <= 1'b1;
            end else begin
              r_state  <= ST_FETCH;
              r_rom_cs <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rom_cs    <= 1'b0;
          r_chr_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_cs    = r_rom_cs;
  assign bus.rom_adr   = w_adr;
  assign bus.chr       = r_chr;
  assign bus.chr_valid = r_chr_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_trunc       = r_trunc;
  assign o_chr_cnt     = r_chr_cnt;

endmodule

// File: tb/tb_rom_msg_sequencer.sv
// Self-checking bench: registered ROM model, character scoreboard, timing and boundary checks.
module tb_rom_msg_sequencer;
  import rom_msg_sequencer_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic [ADR_W-1:0] i_base_adr;
  logic [ADR_W-1:0] i_max_len;
  logic             o_busy;
  logic             o_done;
  logic             o_trunc;
  logic [ADR_W-1:0] o_chr_cnt;

  rom_msg_sequencer_if bus ();

  rom_msg_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_base_adr (i_base_adr),
    .i_max_len  (i_max_len),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_trunc    (o_trunc),
    .o_chr_cnt  (o_chr_cnt),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1<<ADR_W)-1];
  logic [DATA_W-1:0] rom_q = 8'h00;

  always @(posedge clk) begin
    if (bus.rom_cs) rom_q <= mem[bus.rom_adr];
  end
  assign bus.rom_data = rom_q;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check_eq("rst_busy",  o_busy, 0);
    check_eq("rst_done",  o_done, 0);
    check_eq("rst_trunc", o_trunc, 0);
    check_eq("rst_cnt",   o_chr_cnt, 0);
    check_eq("rst_cs",    bus.rom_cs, 0);
    check_eq("rst_adr",   bus.rom_adr, 0);
    check_eq("rst_chr",   bus.chr, 0);
    check_eq("rst_valid", bus.chr_valid, 0);
  endtask

  // One message: build expectations from the ROM image, then drive and score it.
  task automatic run_msg(input logic [ADR_W-1:0] base, input logic [ADR_W-1:0] mlen,
                         input int stall_idx, input int stall_n, input bit spam,
                         input int exp_first_valid, input int exp_done_cyc);
    logic [ADR_W-1:0] a = base;
    int cnt = 0;
    bit tr = 1'b0;
    int idx = 0, stall_ctr = 0, cyc = 0, first_valid = -1, done_cyc = -1;
    int busy_cyc = 0, bad_fetch = 0, stall_cs = 0;
    bit done_seen = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      if (mem[a] == TERM_CHAR) break;
      exp_q.push_back(mem[a]);
      cnt++;
      a = a + 1'b1;
      if (mlen != 0 && cnt == int'(mlen)) begin
        tr = 1'b1;
        break;
      end
    end
    @(negedge clk);
    i_base_adr = base;
    i_max_len = mlen;
    i_start = 1'b1;
    bus.chr_ready = 1'b1;
    while (cyc < 200 && !done_seen) begin
      @(negedge clk);
      cyc++;
      i_start = spam;
      if (o_busy) busy_cyc++;
      if (bus.rom_cs && tr && bus.rom_adr == a) bad_fetch++;
      if (bus.chr_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          check_eq("extra_chr", bus.chr, 32'hFFFF);
          bus.chr_ready = 1'b1;
        end else if (idx == stall_idx && stall_ctr < stall_n) begin
          check_eq("stall_chr", bus.chr, exp_q[0]);
          if (bus.rom_cs) stall_cs++;
          stall_ctr++;
          bus.chr_ready = 1'b0;
        end else begin
          check_eq("chr", bus.chr, exp_q.pop_front());
          idx++;
          bus.chr_ready = 1'b1;
        end
      end else begin
        bus.chr_ready = 1'($urandom_range(0, 1));
      end
      if (o_done) begin
        done_seen = 1'b1;
        done_cyc = cyc;
        check_eq("done_trunc", o_trunc, tr);
        check_eq("done_cnt", o_chr_cnt, cnt);
      end
    end
    check_eq("done_seen", done_seen, 1);
    check_eq("q_left", exp_q.size(), 0);
    check_eq("busy_span", busy_cyc, done_cyc);
    if (tr) check_eq("fetch_past_len", bad_fetch, 0);
    if (stall_n > 0) begin
      check_eq("stall_len", stall_ctr, stall_n);
      check_eq("stall_cs", stall_cs, 0);
    end
    if (exp_first_valid >= 0) check_eq("first_valid_lat", first_valid, exp_first_valid);
    if (exp_done_cyc >= 0) begin
      check_eq("done_lat", done_cyc, exp_done_cyc);
      check_eq("never_valid", first_valid, 32'hFFFF_FFFF);
    end
    @(negedge clk);
    i_start = 1'b0;
    bus.chr_ready = 1'b1;
    check_eq("post_busy", o_busy, 0);
    check_eq("post_done", o_done, 0);
    @(negedge clk);
    check_eq("idle_busy", o_busy, 0);
    check_eq("hold_trunc", o_trunc, tr);
    check_eq("hold_cnt", o_chr_cnt, cnt);
  endtask

  initial begin
    for (int k = 0; k < (1 << ADR_W); k++) mem[k] = 8'h2A;
    mem[0] = 8'h53;
    mem[1] = 8'h4F;
    mem[2] = 8'h53;
    mem[3] = 8'h00;
    mem[17'h1FFFF] = 8'h41;
    rst = 1'b1;
    i_start = 1'b0;
    i_base_adr = '0;
    i_max_len = '0;
    bus.chr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    run_msg(17'd0, 17'd0, -1, 0, 1'b0, 3, -1);
    run_msg(17'd0, 17'd0, 1, 5, 1'b0, -1, -1);
    run_msg(17'd0, 17'd2, -1, 0, 1'b0, -1, -1);
    run_msg(17'd0, 17'd3, -1, 0, 1'b0, -1, -1);

    mem[0] = 8'h00;
    run_msg(17'h1FFFF, 17'd0, -1, 0, 1'b0, 3, -1);
    check_eq("wrap_adr", bus.rom_adr, 0);
    mem[0] = 8'h53;

    run_msg(17'd3, 17'd0, -1, 0, 1'b0, -1, 3);
    run_msg(17'd0, 17'd0, 2, 3, 1'b1, -1, -1);

    // Reset while a character is being presented.
    @(negedge clk);
    i_base_adr = 17'd0;
    i_max_len = 17'd0;
    i_start = 1'b1;
    bus.chr_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 20 && !bus.chr_valid; k++) @(negedge clk);
    check_eq("reach_present", bus.chr_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    run_msg(17'd0, 17'd0, -1, 0, 1'b0, 3, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
